// File: rtl/spi_slave_wide_pkg.sv
// Shared definitions for the wide SPI slave: SPI mode encodings and FSM states.
package spi_slave_wide_pkg;

  // SPI modes encoded as {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_slave_wide_sync.sv
// N-flop synchroniser with asynchronous reset to a configurable level.
module spi_sync #(
  parameter int STAGES    = 2,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the asynchronous input through the synchroniser chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {STAGES{RESET_VAL}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/spi_slave_wide.sv
// Oversampling SPI slave with configurable word width, mode and bit order.
// Pins are synchronised into clk, edges detected with one extra register,
// and a three-state FSM (WAIT_IDLE / IDLE / ACTIVE) frames the words.
import spi_slave_wide_pkg::*;

module spi_slave_wide #(
  parameter int WIDTH       = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SCK,
  input  logic             SSEL,
  input  logic             MOSI,
  output logic             MISO,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ack,
  output logic             busy,
  output logic             frame_abort
);

  localparam int               CNT_W     = $clog2(WIDTH + 1);
  localparam int               FLUSH_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [1:0]       MODE      = {CPOL, CPHA};
  localparam bit               LEAD_RISE = (MODE == SPI_MODE0) || (MODE == SPI_MODE1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_MAX = FLUSH_W'(SYNC_STAGES + 1);

  logic sck_s, ssel_s, mosi_s;
  logic sck_d_r, ssel_d_r;
  logic lead_s, trail_s, sample_s, shift_s, ssel_fall_s, ssel_rise_s;
  logic [FLUSH_W-1:0] flush_r;
  spi_state_e state_r, state_nxt_s;
  logic [CNT_W-1:0] bitcnt_r;
  logic [WIDTH-1:0] rx_shift_r, rx_shift_nxt_s, tx_shift_r, tx_shift_nxt_s;
  logic [WIDTH-1:0] rx_data_r;
  logic skip_r, rx_valid_r, tx_ack_r, abort_r, miso_r, miso_nxt_s, busy_r;
  logic start_s, word_done_s, abort_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck  (.clk(clk), .rst(rst), .d(SCK),  .q(sck_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ssel (.clk(clk), .rst(rst), .d(SSEL), .q(ssel_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(MOSI), .q(mosi_s));

  // Previous synchronised levels for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_d_r  <= 1'b0;
      ssel_d_r <= 1'b1;
    end else begin
      sck_d_r  <= sck_s;
      ssel_d_r <= ssel_s;
    end
  end

  // Decode sample/shift edges from the SPI mode
  always_comb begin
    if (LEAD_RISE) begin
      lead_s  = sck_s & ~sck_d_r;
      trail_s = ~sck_s & sck_d_r;
    end else begin
      lead_s  = ~sck_s & sck_d_r;
      trail_s = sck_s & ~sck_d_r;
    end
    if (CPHA) begin
      sample_s = trail_s;
      shift_s  = lead_s;
    end else begin
      sample_s = lead_s;
      shift_s  = trail_s;
    end
    ssel_fall_s = ssel_d_r & ~ssel_s;
    ssel_rise_s = ~ssel_d_r & ssel_s;
  end

  // The SSEL synchroniser resets high, so its output only reflects the pin
  // after the chain has flushed; WAIT_IDLE must not trust it before then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_r <= {FLUSH_W{1'b0}};
    end else if (flush_r != FLUSH_MAX) begin
      flush_r <= flush_r + FLUSH_W'(1);
    end else begin
      flush_r <= flush_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= WAIT_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      WAIT_IDLE: begin
        if ((flush_r == FLUSH_MAX) && ssel_s) state_nxt_s = IDLE;
        else                                  state_nxt_s = WAIT_IDLE;
      end
      IDLE: begin
        if (ssel_fall_s) state_nxt_s = ACTIVE;
        else             state_nxt_s = IDLE;
      end
      ACTIVE: begin
        if (ssel_rise_s) state_nxt_s = IDLE;
        else             state_nxt_s = ACTIVE;
      end
      default: state_nxt_s = WAIT_IDLE;
    endcase
  end

  // FSM outputs: frame events, next shift-register contents and MISO level
  always_comb begin
    start_s     = (state_r == IDLE) && ssel_fall_s;
    word_done_s = (state_r == ACTIVE) && sample_s && (bitcnt_r == LAST_BIT);
    // A partial word exists if bits were counted or a non-final sample lands now
    abort_s     = (state_r == ACTIVE) && ssel_rise_s && !word_done_s &&
                  ((bitcnt_r != {CNT_W{1'b0}}) || sample_s);
    if (MSB_FIRST) begin
      rx_shift_nxt_s = {rx_shift_r[WIDTH-2:0], mosi_s};
    end else begin
      rx_shift_nxt_s = {mosi_s, rx_shift_r[WIDTH-1:1]};
    end
    // tx_data is captured in the tx_ack cycle; skip_r holds off the one shift
    // edge that would otherwise discard the freshly presented first bit.
    tx_shift_nxt_s = tx_shift_r;
    if (tx_ack_r) begin
      tx_shift_nxt_s = tx_data;
    end else if ((state_r == ACTIVE) && shift_s && !skip_r) begin
      if (MSB_FIRST) tx_shift_nxt_s = {tx_shift_r[WIDTH-2:0], 1'b0};
      else           tx_shift_nxt_s = {1'b0, tx_shift_r[WIDTH-1:1]};
    end else begin
      tx_shift_nxt_s = tx_shift_r;
    end
    if (state_nxt_s == ACTIVE) begin
      miso_nxt_s = MSB_FIRST ? tx_shift_nxt_s[WIDTH-1] : tx_shift_nxt_s[0];
    end else begin
      miso_nxt_s = 1'b0;
    end
  end

  // Datapath: bit counter, shift registers, handshake pulses and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitcnt_r   <= {CNT_W{1'b0}};
      rx_shift_r <= {WIDTH{1'b0}};
      tx_shift_r <= {WIDTH{1'b0}};
      rx_data_r  <= {WIDTH{1'b0}};
      skip_r     <= 1'b0;
      rx_valid_r <= 1'b0;
      tx_ack_r   <= 1'b0;
      abort_r    <= 1'b0;
      miso_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      tx_shift_r <= tx_shift_nxt_s;
      miso_r     <= miso_nxt_s;
      busy_r     <= (state_nxt_s == ACTIVE);
      rx_valid_r <= 1'b0;
      tx_ack_r   <= 1'b0;
      abort_r    <= abort_s;
      if (start_s) begin
        bitcnt_r <= {CNT_W{1'b0}};
        tx_ack_r <= 1'b1;
        skip_r   <= CPHA;
      end else if (state_r == ACTIVE) begin
        if (sample_s) begin
          rx_shift_r <= rx_shift_nxt_s;
          if (word_done_s) begin
            rx_data_r  <= rx_shift_nxt_s;
            rx_valid_r <= 1'b1;
            bitcnt_r   <= {CNT_W{1'b0}};
            tx_ack_r   <= 1'b1;
            skip_r     <= 1'b1;
          end else begin
            bitcnt_r <= bitcnt_r + CNT_W'(1);
          end
        end else if (shift_s && skip_r) begin
          skip_r <= 1'b0;
        end else begin
          skip_r <= skip_r;
        end
        if (ssel_rise_s && !word_done_s) begin
          bitcnt_r <= {CNT_W{1'b0}};
        end
      end else begin
        bitcnt_r <= {CNT_W{1'b0}};
      end
    end
  end

  assign MISO        = miso_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign tx_ack      = tx_ack_r;
  assign busy        = busy_r;
  assign frame_abort = abort_r;

endmodule

// File: tb/tb_spi_slave_wide.sv
// Scoreboard bench for spi_slave_wide: three instances cover mode 0 MSB-first
// 8-bit, mode 3 LSB-first 16-bit and mode 1 MSB-first 8-bit.
module tb_spi_slave_wide;

  localparam int H = 6;  // SCK half period in clk cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] sck_v  = 3'b010;
  logic [2:0] ssel_v = 3'b111;
  logic [2:0] mosi_v = 3'b000;
  logic [2:0] miso_v;

  logic [7:0]  rx_data0, rx_data2, tx_data0, tx_data2;
  logic [15:0] rx_data1, tx_data1;
  logic rx_valid0, rx_valid1, rx_valid2;
  logic tx_ack0, tx_ack1, tx_ack2;
  logic busy0, busy1, busy2;
  logic frame_abort0, frame_abort1, frame_abort2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_samp[3];
  int abort_cnt[3];
  int ack_cnt0 = 0;
  int rxv_cnt0 = 0;
  logic [15:0] q0[$], q1[$], q2[$];
  logic [7:0]  txq0[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  spi_slave_wide u0 (
    .clk(clk), .rst(rst), .SCK(sck_v[0]), .SSEL(ssel_v[0]), .MOSI(mosi_v[0]),
    .MISO(miso_v[0]), .rx_data(rx_data0), .rx_valid(rx_valid0), .tx_data(tx_data0),
    .tx_ack(tx_ack0), .busy(busy0), .frame_abort(frame_abort0));

  spi_slave_wide #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) u1 (
    .clk(clk), .rst(rst), .SCK(sck_v[1]), .SSEL(ssel_v[1]), .MOSI(mosi_v[1]),
    .MISO(miso_v[1]), .rx_data(rx_data1), .rx_valid(rx_valid1), .tx_data(tx_data1),
    .tx_ack(tx_ack1), .busy(busy1), .frame_abort(frame_abort1));

  spi_slave_wide #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u2 (
    .clk(clk), .rst(rst), .SCK(sck_v[2]), .SSEL(ssel_v[2]), .MOSI(mosi_v[2]),
    .MISO(miso_v[2]), .rx_data(rx_data2), .rx_valid(rx_valid2), .tx_data(tx_data2),
    .tx_ack(tx_ack2), .busy(busy2), .frame_abort(frame_abort2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pop the expected word for instance k and compare value and latency
  task automatic mon_one(input int k, input logic [15:0] d);
    logic [15:0] e;
    int n;
    case (k)
      0: n = q0.size();
      1: n = q1.size();
      default: n = q2.size();
    endcase
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_rx_valid inst %0d: got %h expected no word", k, d);
    end else begin
      case (k)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      check($sformatf("rx_data_inst%0d", k), 32'(d), 32'(e));
      check($sformatf("rx_latency_inst%0d", k), 32'(cyc - last_samp[k]), 32'd3);
    end
  endtask

  // Monitor: compare every rx_valid against the scoreboard, count pulses
  always @(negedge clk) begin
    if (rx_valid0) begin
      rxv_cnt0++;
      mon_one(0, {8'h00, rx_data0});
    end
    if (rx_valid1) mon_one(1, rx_data1);
    if (rx_valid2) mon_one(2, {8'h00, rx_data2});
    if (frame_abort0) abort_cnt[0]++;
    if (frame_abort1) abort_cnt[1]++;
    if (frame_abort2) abort_cnt[2]++;
    if (tx_ack0) ack_cnt0++;
  end

  // Transmit producer for u0: after each ack, present the next queued word
  initial begin
    forever begin
      @(negedge clk);
      if (tx_ack0 && (txq0.size() > 0)) begin
        @(posedge clk);
        #1;
        tx_data0 = txq0.pop_front();
      end
    end
  end

  task automatic frame_start(input int idx);
    ssel_v[idx] = 1'b0;
    wait_clk(8);
  endtask

  task automatic frame_end(input int idx);
    wait_clk(H);
    ssel_v[idx] = 1'b1;
    wait_clk(8);
  endtask

  // Master: clock nbits of word, capturing MISO at each sample edge
  task automatic xfer(input int idx, input int width, input bit cpha, input bit msb,
                      input logic [15:0] word, input int nbits, input bit coin,
                      output logic [15:0] mw);
    mw = 16'h0000;
    for (int i = 0; i < nbits; i++) begin
      int b;
      b = msb ? (width - 1 - i) : i;
      if (!cpha) begin
        mosi_v[idx] = word[b];
        wait_clk(H);
        mw[b] = miso_v[idx];
        sck_v[idx] = ~sck_v[idx];
        last_samp[idx] = cyc;
        if (coin && (i == nbits - 1)) begin
          ssel_v[idx] = 1'b1;
        end else begin
          wait_clk(H);
          sck_v[idx] = ~sck_v[idx];
        end
      end else begin
        sck_v[idx] = ~sck_v[idx];
        mosi_v[idx] = word[b];
        wait_clk(H);
        mw[b] = miso_v[idx];
        sck_v[idx] = ~sck_v[idx];
        last_samp[idx] = cyc;
        wait_clk(H);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mw;
    int base;
    for (int k = 0; k < 3; k++) begin
      last_samp[k] = 0;
      abort_cnt[k] = 0;
    end
    tx_data0 = 8'h00;
    tx_data1 = 16'h1234;
    tx_data2 = 8'h96;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(10);

    // Reset state
    check("reset_rx_data", 32'(rx_data0), 32'h0);
    check("reset_rx_valid", 32'(rx_valid0), 32'h0);
    check("reset_busy", 32'(busy0), 32'h0);
    check("reset_miso", 32'(miso_v[0]), 32'h0);
    check("reset_tx_ack", 32'(tx_ack0), 32'h0);
    check("reset_frame_abort", 32'(frame_abort0), 32'h0);

    // Mode 0: back-to-back 0xEA, 0x01 with transmit words 0x5A, 0xC3
    tx_data0 = 8'h5A;
    txq0.push_back(8'hC3);
    base = ack_cnt0;
    frame_start(0);
    check("busy_in_frame", 32'(busy0), 32'h1);
    q0.push_back(16'h00EA);
    xfer(0, 8, 1'b0, 1'b1, 16'h00EA, 8, 1'b0, mw);
    check("miso_word0", 32'(mw), 32'h5A);
    q0.push_back(16'h0001);
    xfer(0, 8, 1'b0, 1'b1, 16'h0001, 8, 1'b0, mw);
    check("miso_word1", 32'(mw), 32'hC3);
    frame_end(0);
    check("tx_ack_at_least_two", 32'((ack_cnt0 - base) >= 2), 32'h1);
    check("busy_after_frame", 32'(busy0), 32'h0);

    // 16-bit mode 3 LSB-first
    frame_start(1);
    q1.push_back(16'hBEEF);
    xfer(1, 16, 1'b1, 1'b0, 16'hBEEF, 16, 1'b0, mw);
    check("miso_w16_lsb", 32'(mw), 32'h1234);
    frame_end(1);

    // Mode 1: full word, then a 5-bit aborted frame
    frame_start(2);
    q2.push_back(16'h003C);
    xfer(2, 8, 1'b1, 1'b1, 16'h003C, 8, 1'b0, mw);
    check("miso_mode1", 32'(mw), 32'h96);
    frame_end(2);
    frame_start(2);
    xfer(2, 8, 1'b1, 1'b1, 16'h00F0, 5, 1'b0, mw);
    frame_end(2);
    check("abort_count_mode1", 32'(abort_cnt[2]), 32'd1);
    check("rx_data_retained", 32'(rx_data2), 32'h3C);
    check("busy_after_abort", 32'(busy2), 32'h0);

    // Reset mid-word with SSEL held low
    tx_data0 = 8'h00;
    frame_start(0);
    xfer(0, 8, 1'b0, 1'b1, 16'h00FF, 3, 1'b0, mw);
    wait_clk(2);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_rx_data", 32'(rx_data0), 32'h0);
    check("rst_mid_rx_valid", 32'(rx_valid0), 32'h0);
    check("rst_mid_busy", 32'(busy0), 32'h0);
    check("rst_mid_miso", 32'(miso_v[0]), 32'h0);
    check("rst_mid_tx_ack", 32'(tx_ack0), 32'h0);
    check("rst_mid_frame_abort", 32'(frame_abort0), 32'h0);
    wait_clk(6);
    base = rxv_cnt0;
    xfer(0, 8, 1'b0, 1'b1, 16'h0055, 8, 1'b0, mw);
    wait_clk(8);
    check("no_rx_after_rst", 32'(rxv_cnt0 - base), 32'd0);
    frame_end(0);
    frame_start(0);
    q0.push_back(16'h0077);
    xfer(0, 8, 1'b0, 1'b1, 16'h0077, 8, 1'b0, mw);
    frame_end(0);

    // Final sample edge coincident with SSEL rise
    frame_start(0);
    q0.push_back(16'h00A5);
    xfer(0, 8, 1'b0, 1'b1, 16'h00A5, 8, 1'b1, mw);
    wait_clk(8);
    sck_v[0] = 1'b0;
    wait_clk(8);
    check("coincident_no_abort", 32'(abort_cnt[0]), 32'd0);
    check("coincident_busy", 32'(busy0), 32'h0);

    wait_clk(10);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q2_drained", 32'(q2.size()), 32'd0);
    check("abort_count_inst1", 32'(abort_cnt[1]), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
